// File: rtl/u712_reg_arb.sv
// u712_reg_arb: arbitrates the chipset register-cycle engine between the
// 68040 CPU and the PCI bridge, with a fairness streak so CPU traffic cannot
// starve PCI. All state changes on the falling edge of CLK80.
// Optional WAIT_TACK bus-timeout abort: define REG_ARB_TIMEOUT_EN.
module u712_reg_arb #(
  parameter int MAX_CPU_BURST  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic CLK80,
  input  logic RESETn,
  input  logic TSn,
  input  logic REGSPACEn,
  input  logic PCI_REQ,
  input  logic REG_TACK,
  input  logic REG_IDLE,
  output logic REG_START,
  output logic GNT_CPU,
  output logic GNT_PCI,
  output logic CPU_TACK,
  output logic PCI_ACK,
  output logic REG_TEA
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_TACK, WAIT_IDLE} state_t;

  state_t     state, state_next;
  logic       cpu_pend, cpu_pend_next;
  logic [3:0] streak, streak_next;
  logic       gnt_cpu_next, gnt_pci_next;
  logic       reg_start_next, cpu_tack_next, pci_ack_next;
  logic       cpu_req, cpu_want, cpu_wins;

`ifdef REG_ARB_TIMEOUT_EN
  logic [9:0] tmo_cnt, tmo_cnt_next;
  logic       reg_tea_next;
`else
  logic [9:0] timeout_unused;
  assign timeout_unused = 10'(TIMEOUT_CYCLES);
  assign REG_TEA = 1'b0;
`endif

  // A fresh register-space transfer start competes in the same clock it is
  // seen, so a CPU and PCI request arriving together resolve in CPU's favour.
  assign cpu_req  = ~TSn & ~REGSPACEn;
  assign cpu_want = cpu_pend | cpu_req;
  assign cpu_wins = cpu_want & (~PCI_REQ | (streak < 4'(MAX_CPU_BURST)));

  // Next-state, grant, streak and pulse outputs for the arbitration sequence.
  always_comb begin
    state_next     = state;
    cpu_pend_next  = cpu_pend | cpu_req;
    streak_next    = streak;
    gnt_cpu_next   = GNT_CPU;
    gnt_pci_next   = GNT_PCI;
    reg_start_next = 1'b0;
    cpu_tack_next  = 1'b0;
    pci_ack_next   = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
    tmo_cnt_next   = tmo_cnt;
    reg_tea_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cpu_wins) begin
          state_next    = GRANT;
          gnt_cpu_next  = 1'b1;
          // The grant serves the oldest request: a latched one keeps a new
          // TSn pending, while a fresh TSn alone is consumed outright.
          cpu_pend_next = cpu_pend & cpu_req;
          if (PCI_REQ)
            streak_next = (streak == 4'd15) ? streak : streak + 4'd1;
          else
            streak_next = 4'd0;
        end else if (PCI_REQ) begin
          state_next   = GRANT;
          gnt_pci_next = 1'b1;
          streak_next  = 4'd0;
        end
      end
      GRANT: begin
        reg_start_next = 1'b1;
        state_next     = WAIT_TACK;
`ifdef REG_ARB_TIMEOUT_EN
        tmo_cnt_next   = '0;
`endif
      end
      WAIT_TACK: begin
        if (REG_TACK) begin
          cpu_tack_next = GNT_CPU;
          pci_ack_next  = GNT_PCI;
          state_next    = WAIT_IDLE;
        end
`ifdef REG_ARB_TIMEOUT_EN
        else if (tmo_cnt == 10'(TIMEOUT_CYCLES - 1)) begin
          reg_tea_next = 1'b1;
          gnt_cpu_next = 1'b0;
          gnt_pci_next = 1'b0;
          state_next   = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + 10'd1;
        end
`endif
      end
      WAIT_IDLE: begin
        if (REG_IDLE) begin
          gnt_cpu_next = 1'b0;
          gnt_pci_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: begin
        gnt_cpu_next = 1'b0;
        gnt_pci_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  // State, request latch, streak and registered outputs; reset aborts at once.
  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      state     <= IDLE;
      cpu_pend  <= 1'b0;
      streak    <= 4'd0;
      GNT_CPU   <= 1'b0;
      GNT_PCI   <= 1'b0;
      REG_START <= 1'b0;
      CPU_TACK  <= 1'b0;
      PCI_ACK   <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_pend  <= cpu_pend_next;
      streak    <= streak_next;
      GNT_CPU   <= gnt_cpu_next;
      GNT_PCI   <= gnt_pci_next;
      REG_START <= reg_start_next;
      CPU_TACK  <= cpu_tack_next;
      PCI_ACK   <= pci_ack_next;
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  // WAIT_TACK timeout counter and the abort pulse it raises.
  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      tmo_cnt <= '0;
      REG_TEA <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_next;
      REG_TEA <= reg_tea_next;
    end
  end
`endif

endmodule

// File: tb/tb_u712_reg_arb.sv
// tb_u712_reg_arb: randomized self-checking bench for u712_reg_arb. The bench
// plays CPU, PCI bridge and register engine; a transaction-level model
// (pending flags plus a streak count) predicts each arbitration winner.
// Timeout scenarios run when REG_ARB_TIMEOUT_EN is defined.
module tb_u712_reg_arb;

  localparam int MAX_BURST = 4;
  localparam int TMO       = 8;

  logic CLK80 = 1'b0;
  logic RESETn = 1'b0;
  logic TSn = 1'b1, REGSPACEn = 1'b1, PCI_REQ = 1'b0;
  logic REG_TACK = 1'b0, REG_IDLE = 1'b1;
  logic REG_START, GNT_CPU, GNT_PCI, CPU_TACK, PCI_ACK, REG_TEA;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Transaction-level model state
  int m_cpu_pend = 0;
  int m_streak = 0;
  logic last_gnt_cpu;

  u712_reg_arb #(.MAX_CPU_BURST(MAX_BURST), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK80(CLK80), .RESETn(RESETn), .TSn(TSn), .REGSPACEn(REGSPACEn),
    .PCI_REQ(PCI_REQ), .REG_TACK(REG_TACK), .REG_IDLE(REG_IDLE),
    .REG_START(REG_START), .GNT_CPU(GNT_CPU), .GNT_PCI(GNT_PCI),
    .CPU_TACK(CPU_TACK), .PCI_ACK(PCI_ACK), .REG_TEA(REG_TEA)
  );

  initial forever #6 CLK80 = ~CLK80;

  // Inputs set before cycle() are sampled by the next falling edge; outputs
  // read after cycle() show that edge's result.
  task automatic cycle();
    @(posedge CLK80);
    #1;
  endtask

  // One complete register cycle; the winner comes from the arbitration rules.
  task automatic run_txn(input bit new_cpu, input bit new_pci, input int tack_dly,
                         input int idle_dly, input bit side, input bit withdraw);
    bit cpu_want, pci_want, exp_cpu, side_reg;
    if (new_cpu) begin TSn = 1'b0; REGSPACEn = 1'b0; end
    if (new_pci) PCI_REQ = 1'b1;
    cpu_want = (m_cpu_pend != 0) || new_cpu;
    pci_want = PCI_REQ;
    exp_cpu  = cpu_want && (!pci_want || m_streak < MAX_BURST);
    if (exp_cpu) begin
      m_streak   = pci_want ? ((m_streak >= 15) ? 15 : m_streak + 1) : 0;
      m_cpu_pend = 0;
    end else begin
      m_streak   = 0;
      m_cpu_pend = cpu_want ? 1 : 0;
    end
    cycle();
    TSn = 1'b1; REGSPACEn = 1'b1;
    last_gnt_cpu = GNT_CPU;
    total_cnt++;
    if ({GNT_CPU, GNT_PCI, REG_START} !== {exp_cpu, !exp_cpu, 1'b0})
      $display("[TB] FAIL grant: got cpu/pci/start=%b%b%b want %b%b0", GNT_CPU, GNT_PCI, REG_START, exp_cpu, !exp_cpu);
    else pass_cnt++;
    cycle();
    REG_IDLE = 1'b0;
    total_cnt++;
    if ({REG_START, GNT_CPU, GNT_PCI} !== {1'b1, exp_cpu, !exp_cpu})
      $display("[TB] FAIL start: got start/cpu/pci=%b%b%b want 1%b%b", REG_START, GNT_CPU, GNT_PCI, exp_cpu, !exp_cpu);
    else pass_cnt++;
    for (int d = 0; d < tack_dly; d++) begin
      if (side && d == 0 && m_cpu_pend == 0) begin
        side_reg = 1'($urandom % 2);
        TSn = 1'b0; REGSPACEn = side_reg;
        if (!side_reg) m_cpu_pend = 1;
      end
      cycle();
      TSn = 1'b1; REGSPACEn = 1'b1;
      total_cnt++;
      if ({REG_START, CPU_TACK, PCI_ACK, REG_TEA} !== 4'b0000)
        $display("[TB] FAIL tack_wait: got start/ctack/pack/tea=%b%b%b%b want 0000", REG_START, CPU_TACK, PCI_ACK, REG_TEA);
      else pass_cnt++;
    end
    REG_TACK = 1'b1;
    cycle();
    REG_TACK = 1'b0;
    total_cnt++;
    if ({CPU_TACK, PCI_ACK, REG_TEA} !== {exp_cpu, !exp_cpu, 1'b0})
      $display("[TB] FAIL ack: got ctack/pack/tea=%b%b%b want %b%b0", CPU_TACK, PCI_ACK, REG_TEA, exp_cpu, !exp_cpu);
    else pass_cnt++;
    if (!exp_cpu) PCI_REQ = 1'b0;
    for (int d = 0; d < idle_dly; d++) begin
      if (withdraw && d == 0) PCI_REQ = 1'b1;
      if (withdraw && d == 2) PCI_REQ = 1'b0;
      cycle();
      total_cnt++;
      if ({GNT_CPU, GNT_PCI, CPU_TACK, PCI_ACK} !== {exp_cpu, !exp_cpu, 2'b00})
        $display("[TB] FAIL hold: got cpu/pci/ctack/pack=%b%b%b%b want %b%b00", GNT_CPU, GNT_PCI, CPU_TACK, PCI_ACK, exp_cpu, !exp_cpu);
      else pass_cnt++;
    end
    PCI_REQ = withdraw ? 1'b0 : PCI_REQ;
    REG_IDLE = 1'b1;
    cycle();
    total_cnt++;
    if ({GNT_CPU, GNT_PCI} !== 2'b00)
      $display("[TB] FAIL release: got cpu/pci=%b%b want 00", GNT_CPU, GNT_PCI);
    else pass_cnt++;
  endtask

  // Reset holds every output low; release leaves the arbiter idle.
  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) cycle();
    total_cnt++;
    if ({REG_START, GNT_CPU, GNT_PCI, CPU_TACK, PCI_ACK, REG_TEA} !== 6'b0)
      $display("[TB] FAIL reset_outputs: got %b want 000000", {REG_START, GNT_CPU, GNT_PCI, CPU_TACK, PCI_ACK, REG_TEA});
    else pass_cnt++;
    RESETn = 1'b1;
    m_cpu_pend = 0;
    m_streak = 0;
    repeat (2) cycle();
    total_cnt++;
    if ({GNT_CPU, GNT_PCI, REG_START} !== 3'b000)
      $display("[TB] FAIL idle_after_reset: got %b want 000", {GNT_CPU, GNT_PCI, REG_START});
    else pass_cnt++;
  endtask

  // Lone CPU request runs a full cycle and the arbiter then stays idle.
  task automatic test_cpu_only();
    run_txn(1, 0, 2, 1, 0, 0);
    repeat (2) cycle();
    total_cnt++;
    if ({GNT_CPU, GNT_PCI, REG_START} !== 3'b000)
      $display("[TB] FAIL cpu_only_idle: got %b want 000", {GNT_CPU, GNT_PCI, REG_START});
    else pass_cnt++;
  endtask

  // CPU and PCI request in the same clock: CPU first, then PCI.
  task automatic test_simultaneous();
    run_txn(1, 1, 1, 1, 0, 0);
    total_cnt++;
    if (last_gnt_cpu !== 1'b1) $display("[TB] FAIL simul_first: got cpu=%b want 1", last_gnt_cpu);
    else pass_cnt++;
    run_txn(0, 0, 0, 2, 0, 0);
    total_cnt++;
    if (last_gnt_cpu !== 1'b0) $display("[TB] FAIL simul_second: got cpu=%b want 0", last_gnt_cpu);
    else pass_cnt++;
  endtask

  // PCI held against constant CPU traffic: four CPU grants, then PCI, and a
  // fresh contest afterwards goes to the CPU again.
  task automatic test_fairness();
    bit tbl_cpu[7] = '{1, 1, 1, 1, 1, 0, 0};
    bit tbl_pci[7] = '{1, 0, 0, 0, 0, 1, 0};
    bit tbl_exp[7] = '{1, 1, 1, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl_cpu[i], tbl_pci[i], i % 3, 1, 0, 0);
      total_cnt++;
      if (last_gnt_cpu !== tbl_exp[i])
        $display("[TB] FAIL fairness_%0d: got cpu=%b want %b", i, last_gnt_cpu, tbl_exp[i]);
      else pass_cnt++;
    end
  endtask

  // A short PCI pulse during a CPU cycle is withdrawn without any grant.
  task automatic test_withdraw();
    run_txn(1, 0, 1, 4, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      total_cnt++;
      if ({GNT_PCI, PCI_ACK, GNT_CPU} !== 3'b000)
        $display("[TB] FAIL withdraw_%0d: got pci/pack/cpu=%b%b%b want 000", i, GNT_PCI, PCI_ACK, GNT_CPU);
      else pass_cnt++;
    end
  endtask

  // Random mix of requests, engine latencies and side traffic.
  task automatic test_random();
    bit nc, np;
    for (int i = 0; i < 40; i++) begin
      nc = (m_cpu_pend == 0) && ($urandom % 2 == 1);
      np = !PCI_REQ && ($urandom % 2 == 1);
      if (m_cpu_pend == 0 && !nc && !PCI_REQ && !np) nc = 1'b1;
      run_txn(nc, np, int'($urandom % 5), int'($urandom % 3), ($urandom % 3) == 0, 0);
    end
    for (int i = 0; i < 3; i++)
      if (m_cpu_pend != 0 || PCI_REQ) run_txn(0, 0, 1, 0, 0, 0);
    repeat (2) cycle();
    total_cnt++;
    if ({GNT_CPU, GNT_PCI} !== 2'b00)
      $display("[TB] FAIL random_drain: got cpu/pci=%b%b want 00", GNT_CPU, GNT_PCI);
    else pass_cnt++;
  endtask

  // Reset in WAIT_TACK clears outputs at once; a late TACK is then ignored.
  task automatic test_reset_midcycle();
    TSn = 1'b0; REGSPACEn = 1'b0;
    cycle();
    TSn = 1'b1; REGSPACEn = 1'b1;
    cycle();
    REG_IDLE = 1'b0;
    total_cnt++;
    if ({REG_START, GNT_CPU} !== 2'b11)
      $display("[TB] FAIL midreset_pre: got start/cpu=%b%b want 11", REG_START, GNT_CPU);
    else pass_cnt++;
    #2 RESETn = 1'b0;
    #1;
    total_cnt++;
    if ({REG_START, GNT_CPU, GNT_PCI, CPU_TACK, PCI_ACK, REG_TEA} !== 6'b0)
      $display("[TB] FAIL midreset_async: got %b want 000000", {REG_START, GNT_CPU, GNT_PCI, CPU_TACK, PCI_ACK, REG_TEA});
    else pass_cnt++;
    cycle();
    RESETn = 1'b1;
    m_cpu_pend = 0;
    m_streak = 0;
    REG_TACK = 1'b1;
    cycle();
    REG_TACK = 1'b0;
    total_cnt++;
    if ({CPU_TACK, PCI_ACK, GNT_CPU, GNT_PCI} !== 4'b0000)
      $display("[TB] FAIL midreset_late_tack: got %b want 0000", {CPU_TACK, PCI_ACK, GNT_CPU, GNT_PCI});
    else pass_cnt++;
    REG_IDLE = 1'b1;
    cycle();
  endtask

`ifdef REG_ARB_TIMEOUT_EN
  // No TACK: abort after TMO clocks in WAIT_TACK; TACK on the last clock wins.
  task automatic test_timeout();
    for (int late = 0; late < 2; late++) begin
      TSn = 1'b0; REGSPACEn = 1'b0;
      cycle();
      TSn = 1'b1; REGSPACEn = 1'b1;
      cycle();
      REG_IDLE = 1'b0;
      m_streak = 0;
      for (int i = 0; i < TMO - 1; i++) begin
        cycle();
        total_cnt++;
        if ({REG_TEA, GNT_CPU, CPU_TACK} !== 3'b010)
          $display("[TB] FAIL tmo_wait_%0d: got tea/cpu/ctack=%b%b%b want 010", i, REG_TEA, GNT_CPU, CPU_TACK);
        else pass_cnt++;
      end
      REG_TACK = late[0];
      cycle();
      REG_TACK = 1'b0;
      total_cnt++;
      if ({REG_TEA, GNT_CPU, CPU_TACK} !== (late ? 3'b011 : 3'b100))
        $display("[TB] FAIL tmo_end_%0d: got tea/cpu/ctack=%b%b%b", late, REG_TEA, GNT_CPU, CPU_TACK);
      else pass_cnt++;
      cycle();
      total_cnt++;
      if ({REG_TEA, CPU_TACK} !== 2'b00)
        $display("[TB] FAIL tmo_after_%0d: got tea/ctack=%b%b want 00", late, REG_TEA, CPU_TACK);
      else pass_cnt++;
      REG_IDLE = 1'b1;
      cycle();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_only();
    test_simultaneous();
    test_fairness();
    test_withdraw();
    test_random();
    test_reset_midcycle();
`ifdef REG_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/u712_reg_arb.md
Name: u712_reg_arb

Overview:
- Arbitrates the chipset register-cycle engine between two requesters: the 68040 CPU and the PCI bridge.
- Latches the CPU request from the transfer-start and register-space decode, and accepts a level request from the PCI bridge.
- Grants one requester, launches the register state machine with a start pulse, relays its termination as a per-requester acknowledge, and holds the grant until the engine returns to idle.
- Includes a fairness counter so CPU traffic cannot starve PCI.

Parameters:
- MAX_CPU_BURST, 4: consecutive CPU grants allowed while PCI is pending before PCI must win. Range 1..15.
- TIMEOUT_CYCLES, 1023: CLK80 cycles in WAIT_TACK before abort. Used only with the optional feature. Counter is 10 bits.

Ports:
- CLK80 input 1: 80 MHz system clock. All state changes on its falling edge.
- RESETn input 1: reset, asynchronous, active-low.
- TSn input 1: CPU transfer start, active-low, one clock wide.
- REGSPACEn input 1: register-space address decode, active-low, valid with TSn.
- PCI_REQ input 1: PCI bridge request, level. Held until PCI_ACK, dropped the clock after.
- REG_TACK input 1: one-clock termination pulse from the register state machine.
- REG_IDLE input 1: high when the register state machine has released ASn (REGENn high).
- REG_START output 1: one-clock start pulse to the register state machine.
- GNT_CPU output 1: CPU owns the register engine.
- GNT_PCI output 1: PCI bridge owns the register engine.
- CPU_TACK output 1: one-clock acknowledge to the CPU termination logic.
- PCI_ACK output 1: one-clock acknowledge to the PCI bridge.
- REG_TEA output 1: one-clock abort pulse. Driven only with the optional feature, otherwise tied 0.

Behaviour:
- Reset: all outputs 0; state IDLE; CPU_PEND=0; streak=0; timeout counter=0. Reset asserted mid-cycle aborts immediately; no acknowledge is issued and pending requests are lost.
- CPU_PEND is set on any clock with TSn=0 and REGSPACEn=0. It is cleared in the clock the CPU is granted. A set and a clear in the same clock leave it set.
- States: IDLE -> GRANT -> WAIT_TACK -> WAIT_IDLE -> IDLE.
- IDLE: if no request, stay.
  - If only one requester is pending, grant it.
  - If both are pending, the CPU wins unless streak >= MAX_CPU_BURST, in which case PCI wins.
  - The grant output asserts on the transition to GRANT.
- GRANT, one clock: REG_START=1. Next state WAIT_TACK.
- WAIT_TACK: on REG_TACK=1, pulse the granted requester's acknowledge (CPU_TACK or PCI_ACK) on the next clock edge, then go to WAIT_IDLE. REG_TACK arriving in any other state is ignored.
- WAIT_IDLE: hold the grant until REG_IDLE=1. Then drop the grant and go to IDLE. There is no back-to-back grant before the engine is idle.
- Grant latency: a request seen in IDLE produces REG_START 2 clocks later (grant clock, then start clock).
- The grant outputs are mutually exclusive and never both 1.
- Streak update, at each grant:
  - CPU granted while PCI_REQ=1: streak+1, saturating at 15.
  - PCI granted: streak=0.
  - CPU granted while PCI_REQ=0: streak=0.
- A PCI_REQ drop before grant withdraws the request with no acknowledge.
- A CPU TSn that lands while a CPU cycle is already granted is latched and served after the current cycle completes.

Optional Feature:
- REG_ARB_TIMEOUT_EN defined:
  - A 10-bit counter clears on entry to WAIT_TACK and increments every clock in WAIT_TACK.
  - At TIMEOUT_CYCLES, without REG_TACK: REG_TEA pulses for 1 clock, the acknowledge is suppressed, the grant drops, and the state returns to IDLE without waiting for REG_IDLE.
  - If REG_TACK and the timeout land in the same clock, REG_TACK wins.
- Undefined: no counter is built, REG_TEA is constant 0, and WAIT_TACK waits indefinitely.

Test Plan:
- CPU only: TSn=0 and REGSPACEn=0 for 1 clock -> GNT_CPU next clock; REG_START 1 clock later. REG_TACK pulse -> CPU_TACK 1 clock later. REG_IDLE=1 -> GNT_CPU=0, state IDLE.
- Simultaneous: CPU and PCI requests in the same clock, streak=0 -> CPU is granted first. PCI is granted after the CPU cycle's REG_IDLE, and PCI_ACK follows its REG_TACK.
- Fairness, MAX_CPU_BURST=4: PCI_REQ held high with a CPU request before every arbitration -> 4 CPU grants, then 1 PCI grant, and streak returns to 0.
- Withdraw: PCI_REQ high 2 clocks during a CPU cycle, then low -> no GNT_PCI and no PCI_ACK.
- Reset mid-cycle: RESETn=0 in WAIT_TACK -> all outputs 0 asynchronously. After release, a late REG_TACK produces no acknowledge.
- With REG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: no REG_TACK -> REG_TEA pulse after 8 clocks in WAIT_TACK, grant dropped, no CPU_TACK. A REG_TACK at clock 8 instead yields CPU_TACK and no REG_TEA.
